// File: rtl/mini_src_pkg.sv
// mini_src_pkg: bus source ids, IR register-field positions and FSM state encoding
package mini_src_pkg;
    localparam logic [4:0] SRC_R0    = 5'd0;
    localparam logic [4:0] SRC_R15   = 5'd15;
    localparam logic [4:0] SRC_HI    = 5'd16;
    localparam logic [4:0] SRC_LO    = 5'd17;
    localparam logic [4:0] SRC_ZHI   = 5'd18;
    localparam logic [4:0] SRC_ZLO   = 5'd19;
    localparam logic [4:0] SRC_PC    = 5'd20;
    localparam logic [4:0] SRC_MDR   = 5'd21;
    localparam logic [4:0] SRC_INP   = 5'd22;
    localparam logic [4:0] SRC_C     = 5'd23;
    localparam int         RA_LSB    = 23;
    localparam int         RB_LSB    = 19;
    localparam int         RC_LSB    = 15;
    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP} state_t;
endpackage

// File: rtl/bus_source_select_if.sv
// bus_source_select_if: request side (control unit) and drive side (bus mux / regfile) of the source selector
//   master: control unit driving requests; slave: the selector
//   req_valid/req_ready handshake, use_ir/src_id/ir/gra/grb/grc source select,
//   ba_out/rin modifiers, out_en/reg_in/ba_zero/busy/sel_err results
interface bus_source_select_if #(parameter int unsigned NUM_SRC = 24);
    logic               req_valid;
    logic               req_ready;
    logic               use_ir;
    logic [4:0]         src_id;
    logic [31:0]        ir;
    logic               gra;
    logic               grb;
    logic               grc;
    logic               ba_out;
    logic               rin;
    logic [NUM_SRC-1:0] out_en;
    logic [15:0]        reg_in;
    logic               ba_zero;
    logic               busy;
    logic               sel_err;
    modport master (
        output req_valid, use_ir, src_id, ir, gra, grb, grc, ba_out, rin,
        input  req_ready, out_en, reg_in, ba_zero, busy, sel_err
    );
    modport slave (
        input  req_valid, use_ir, src_id, ir, gra, grb, grc, ba_out, rin,
        output req_ready, out_en, reg_in, ba_zero, busy, sel_err
    );
endinterface

// File: rtl/bus_source_select_ir_reg_decode.sv
// ir_reg_decode: picks Ra/Rb/Rc from ir by gra > grb > grc priority
//   ir_i, gra_i, grb_i, grc_i in; reg_id_o (4-bit register id), valid_o (some gr* set) out
module ir_reg_decode
    import mini_src_pkg::*;
(
    input  logic [31:0] ir_i,
    input  logic        gra_i,
    input  logic        grb_i,
    input  logic        grc_i,
    output logic [3:0]  reg_id_o,
    output logic        valid_o
);
    always_comb begin
        reg_id_o = gra_i ? ir_i[RA_LSB+:4] : grb_i ? ir_i[RB_LSB+:4] : ir_i[RC_LSB+:4];
        valid_o  = gra_i | grb_i | grc_i;
    end
endmodule

// File: rtl/bus_source_select.sv
// bus_source_select: registered one-hot bus driver select with fixed drive window and turnaround gap
//   clock, clear (sync active-low) plain ports; bus (slave modport) carries request and enables
module bus_source_select
    import mini_src_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 24,
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input logic                 clock,
    input logic                 clear,
    bus_source_select_if.slave  bus
);
    localparam int CW = $clog2(HOLD_CYCLES + GAP_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [4:0]         id_q, id_d;
    logic               ba_q, ba_d, rin_q, rin_d;
    logic [NUM_SRC-1:0] out_en_q, out_en_d;
    logic [15:0]        reg_in_q, reg_in_d;
    logic               ba_zero_q, ba_zero_d, sel_err_q, sel_err_d;
    logic [3:0]         dec_id;
    logic               dec_ok, accept, res_ok, drv, r0_zero;
    logic [4:0]         res_id;

    ir_reg_decode u_dec (
        .ir_i    (bus.ir),
        .gra_i   (bus.gra),
        .grb_i   (bus.grb),
        .grc_i   (bus.grc),
        .reg_id_o(dec_id),
        .valid_o (dec_ok)
    );

    always_comb begin
        accept    = bus.req_valid && state_q == ST_IDLE;
        res_id    = bus.use_ir ? {1'b0, dec_id} : bus.src_id;
        res_ok    = (!bus.use_ir || dec_ok) && 32'(res_id) < NUM_SRC;
        state_d   = state_q;
        cnt_d     = cnt_q;
        id_d      = accept ? res_id : id_q;
        ba_d      = accept ? bus.ba_out : ba_q;
        rin_d     = accept ? bus.rin : rin_q;
        sel_err_d = accept && !res_ok;
        if (state_q == ST_IDLE) begin
            state_d = accept && res_ok ? ST_DRIVE : ST_IDLE;
            cnt_d   = HOLD_LD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (state_q == ST_DRIVE && GAP_CYCLES != 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LD;
        end else begin
            state_d = ST_IDLE;
        end
        // enables are registered off the next state so they line up with state_q
        drv       = state_d == ST_DRIVE;
        r0_zero   = ba_d && id_d == SRC_R0;
        out_en_d  = drv && !r0_zero ? NUM_SRC'(1) << id_d : '0;
        ba_zero_d = drv && r0_zero;
        reg_in_d  = drv && rin_d && id_d <= SRC_R15 ? 16'(1) << id_d[3:0] : '0;
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            id_q      <= '0;
            ba_q      <= 1'b0;
            rin_q     <= 1'b0;
            out_en_q  <= '0;
            reg_in_q  <= '0;
            ba_zero_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            ba_q      <= ba_d;
            rin_q     <= rin_d;
            out_en_q  <= out_en_d;
            reg_in_q  <= reg_in_d;
            ba_zero_q <= ba_zero_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.out_en    = out_en_q;
    assign bus.reg_in    = reg_in_q;
    assign bus.ba_zero   = ba_zero_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.busy      = state_q != ST_IDLE;
    assign bus.req_ready = state_q == ST_IDLE;
endmodule

// File: tb/tb_bus_source_select.sv
// tb_bus_source_select: directed vectors for the bus source selector (HOLD=1/GAP=1 and HOLD=3/GAP=0)
module tb_bus_source_select;
    logic clock = 1'b0;
    logic clear = 1'b0;
    logic rv3   = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    bus_source_select_if #(.NUM_SRC(24)) b1 ();
    bus_source_select_if #(.NUM_SRC(24)) b3 ();

    assign b3.req_valid = rv3;
    assign b3.use_ir    = b1.use_ir;
    assign b3.src_id    = b1.src_id;
    assign b3.ir        = b1.ir;
    assign b3.gra       = b1.gra;
    assign b3.grb       = b1.grb;
    assign b3.grc       = b1.grc;
    assign b3.ba_out    = b1.ba_out;
    assign b3.rin       = b1.rin;

    bus_source_select #(.NUM_SRC(24), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut (
        .clock(clock), .clear(clear), .bus(b1.slave)
    );
    bus_source_select #(.NUM_SRC(24), .HOLD_CYCLES(3), .GAP_CYCLES(0)) dut3 (
        .clock(clock), .clear(clear), .bus(b3.slave)
    );

    typedef struct {
        string       name;
        logic        use_ir;
        logic [4:0]  src_id;
        logic [31:0] ir;
        logic        gra, grb, grc, ba_out, rin;
        logic [23:0] exp_out;
        logic [15:0] exp_reg;
        logic        exp_baz;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_fields(input logic ui, input logic [4:0] sid, input logic [31:0] irv,
                              input logic a, input logic b, input logic c, input logic ba, input logic r);
        b1.use_ir = ui; b1.src_id = sid; b1.ir = irv;
        b1.gra = a; b1.grb = b; b1.grc = c; b1.ba_out = ba; b1.rin = r;
    endtask

    // bus-contention invariant on both instances, every cycle
    always @(negedge clock) begin
        chk("inv_onehot1", 32'($countones(b1.out_en) <= 1 && !(|b1.out_en && b1.ba_zero)), 32'd1);
        chk("inv_onehot3", 32'($countones(b3.out_en) <= 1 && !(|b3.out_en && b3.ba_zero)), 32'd1);
    end

    initial begin
        vecs[0]  = '{"ir_ra",    1, 0,  32'h029B8000, 1, 0, 0, 0, 1, 24'h000020, 16'h0020, 0, 0};
        vecs[1]  = '{"ir_rb_pri",1, 0,  32'h029B8000, 0, 1, 1, 0, 0, 24'h000008, 16'h0000, 0, 0};
        vecs[2]  = '{"ir_rc",    1, 0,  32'h029B8000, 0, 0, 1, 0, 1, 24'h000080, 16'h0080, 0, 0};
        vecs[3]  = '{"src_pc",   0, 20, 32'h0,        0, 0, 0, 0, 1, 24'h100000, 16'h0000, 0, 0};
        vecs[4]  = '{"src_25",   0, 25, 32'h0,        0, 0, 0, 0, 1, 24'h000000, 16'h0000, 0, 1};
        vecs[5]  = '{"ir_nogr",  1, 3,  32'h029B8000, 0, 0, 0, 0, 0, 24'h000000, 16'h0000, 0, 1};
        vecs[6]  = '{"ba_r0",    1, 0,  32'h00000000, 1, 0, 0, 1, 0, 24'h000000, 16'h0000, 1, 0};
        vecs[7]  = '{"src_r0",   0, 0,  32'h0,        0, 0, 0, 0, 1, 24'h000001, 16'h0001, 0, 0};
        vecs[8]  = '{"src_c",    0, 23, 32'h0,        0, 0, 0, 0, 0, 24'h800000, 16'h0000, 0, 0};
        vecs[9]  = '{"src_24",   0, 24, 32'h0,        0, 0, 0, 0, 0, 24'h000000, 16'h0000, 0, 1};
        vecs[10] = '{"src_r15",  0, 15, 32'h0,        0, 0, 0, 1, 1, 24'h008000, 16'h8000, 0, 0};

        set_fields(0, 5'd20, 32'h0, 0, 0, 0, 0, 1);
        b1.req_valid = 1'b1;
        rv3 = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_out_en", 32'(b1.out_en), 32'h0);
        chk("rst_reg_in", 32'(b1.reg_in), 32'h0);
        chk("rst_flags",  {28'h0, b1.ba_zero, b1.busy, b1.sel_err, b1.req_ready}, 32'h1);
        chk("rst_out_en3", 32'(b3.out_en), 32'h0);
        b1.req_valid = 1'b0;
        rv3 = 1'b0;
        clear = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 11; i++) begin
            set_fields(vecs[i].use_ir, vecs[i].src_id, vecs[i].ir, vecs[i].gra,
                       vecs[i].grb, vecs[i].grc, vecs[i].ba_out, vecs[i].rin);
            b1.req_valid = 1'b1;
            @(posedge clock);
            #1 b1.req_valid = 1'b0;
            @(negedge clock);
            chk({vecs[i].name, "_out_en"},  32'(b1.out_en),  32'(vecs[i].exp_out));
            chk({vecs[i].name, "_reg_in"},  32'(b1.reg_in),  32'(vecs[i].exp_reg));
            chk({vecs[i].name, "_ba_zero"}, 32'(b1.ba_zero), 32'(vecs[i].exp_baz));
            chk({vecs[i].name, "_sel_err"}, 32'(b1.sel_err), 32'(vecs[i].exp_err));
            chk({vecs[i].name, "_busy"},    32'(b1.busy),    32'(!vecs[i].exp_err));
            @(negedge clock);
            chk({vecs[i].name, "_gap_en"},  {b1.out_en, b1.reg_in[7:0]} , 32'h0);
            chk({vecs[i].name, "_gap_st"},  {29'h0, b1.ba_zero, b1.busy, b1.sel_err}, {29'h0, 1'b0, !vecs[i].exp_err, 1'b0});
            @(negedge clock);
            chk({vecs[i].name, "_idle"},    {30'h0, b1.busy, b1.req_ready}, 32'h1);
        end

        // HOLD=3 drive with held request and changing src_id, then back-to-back accept
        set_fields(0, 5'd20, 32'h0, 0, 0, 0, 0, 0);
        rv3 = 1'b1;
        @(negedge clock);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("hold3_out_en_%0d", c), 32'(b3.out_en), 32'h100000);
            chk($sformatf("hold3_ready_%0d", c),  32'(b3.req_ready), 32'h0);
            b1.src_id = 5'd5;
            if (c == 2) begin
                b1.src_id = 5'd21;
            end
            @(negedge clock);
        end
        chk("b2b_first_idle", {30'h0, b3.busy, b3.req_ready}, 32'h1);
        chk("b2b_bus_off",    32'(b3.out_en), 32'h0);
        @(negedge clock);
        chk("b2b_out_en", 32'(b3.out_en), 32'h200000);

        // clear mid-drive drops the pending drive
        clear = 1'b0;
        rv3 = 1'b0;
        @(negedge clock);
        chk("clr_out_en", 32'(b3.out_en), 32'h0);
        chk("clr_flags",  {29'h0, b3.ba_zero, b3.busy, b3.req_ready}, 32'h1);
        clear = 1'b1;
        @(negedge clock);
        chk("clr_stays_idle", {31'h0, b3.busy}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
